// File: rtl/elc_scan_controller.sv
// elc_scan_controller: N-floor SCAN elevator controller with timed travel/door phases and alerts; ports clk, reset, req_vec, over_time, over_weight, [emergency when ELC_EMERGENCY_EN] -> current_floor, direction, moving, door_open, complete, door_alert, weight_alert, pending
module elc_scan_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req_vec,
  input  logic                  over_time,
  input  logic                  over_weight,
`ifdef ELC_EMERGENCY_EN
  input  logic                  emergency,
`endif
  output logic [NUM_FLOORS-1:0] current_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  complete,
  output logic                  door_alert,
  output logic                  weight_alert,
  output logic [NUM_FLOORS-1:0] pending
);
  localparam int TMAX = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_MOVE = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] T_DOOR = TW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN} state_t;
  state_t state_q, state_d;
  logic [NUM_FLOORS-1:0] floor_q, floor_d, pending_q, pending_d, req_eff, p_all, nf, serviced;
  logic [TW-1:0] timer_q, timer_d;
  logic dir_q, dir_d, complete_q, complete_d, moving_q, moving_d, door_open_q, door_open_d;
  logic door_alert_q, door_alert_d, weight_alert_q, weight_alert_d, emg;
  logic [1:0] ch;
`ifdef ELC_EMERGENCY_EN
  assign emg = emergency;
`else
  assign emg = 1'b0;
`endif
  // {any pending strictly ahead or behind, next direction}; bits above f are ~((f<<1)-1), below are f-1
  function automatic logic [1:0] choose(input logic [NUM_FLOORS-1:0] p, input logic [NUM_FLOORS-1:0] f, input logic d);
    logic up, dn;
    up = |(p & ~((f << 1) - ONE));
    dn = |(p & (f - ONE));
    choose = {up | dn, ((d ? up : dn) || !(up | dn)) ? d : ~d};
  endfunction
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    complete_d = 1'b0;
    serviced = '0;
    req_eff  = emg ? '0 : req_vec;
    p_all    = pending_q | req_eff;
    nf       = dir_q ? floor_q << 1 : floor_q >> 1;
    ch       = 2'b00;
    case (state_q)
      IDLE: begin
        if (emg) begin
          state_d = floor_q[0] ? DOOR_OPEN : MOVE;
          timer_d = floor_q[0] ? T_DOOR : T_MOVE;
          dir_d   = floor_q[0] ? dir_q : 1'b0;
        end else if (!over_weight && |(p_all & floor_q)) begin
          state_d    = DOOR_OPEN;
          timer_d    = T_DOOR;
          complete_d = 1'b1;
          serviced   = floor_q;
        end else if (!over_weight && |p_all) begin
          ch      = choose(p_all, floor_q, dir_q);
          state_d = MOVE;
          dir_d   = ch[0];
          timer_d = T_MOVE;
        end
      end
      MOVE: begin
        if (timer_q != '0) begin
          timer_d = timer_q - T_ONE;
        end else begin
          floor_d = nf;
          if (emg) begin
            state_d = nf[0] ? DOOR_OPEN : MOVE;
            timer_d = nf[0] ? T_DOOR : T_MOVE;
            dir_d   = 1'b0;
          end else if (|(p_all & nf)) begin
            state_d    = DOOR_OPEN;
            timer_d    = T_DOOR;
            complete_d = 1'b1;
            serviced   = nf;
          end else begin
            ch      = choose(p_all, nf, dir_q);
            state_d = ch[1] ? MOVE : IDLE;
            dir_d   = ch[0];
            timer_d = T_MOVE;
          end
        end
      end
      DOOR_OPEN: begin
        // requests for the open floor are absorbed here without a new complete pulse
        serviced = floor_q;
        if (emg) begin
          state_d = floor_q[0] ? DOOR_OPEN : MOVE;
          timer_d = floor_q[0] ? T_DOOR : T_MOVE;
          dir_d   = floor_q[0] ? dir_q : 1'b0;
        end else if (|(req_eff & floor_q)) begin
          timer_d = T_DOOR;
        end else if (!over_time && !over_weight) begin
          if (timer_q != '0) begin
            timer_d = timer_q - T_ONE;
          end else begin
            ch      = choose(p_all, floor_q, dir_q);
            state_d = ch[1] ? MOVE : IDLE;
            dir_d   = ch[0];
            timer_d = T_MOVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d      = emg ? '0 : p_all & ~serviced;
    moving_d       = state_d == MOVE;
    door_open_d    = state_d == DOOR_OPEN;
    door_alert_d   = (state_q == DOOR_OPEN && over_time) || (emg && state_d == DOOR_OPEN && floor_d[0]);
    weight_alert_d = over_weight && state_q != MOVE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      floor_q        <= ONE;
      dir_q          <= 1'b1;
      pending_q      <= '0;
      timer_q        <= '0;
      complete_q     <= 1'b0;
      moving_q       <= 1'b0;
      door_open_q    <= 1'b0;
      door_alert_q   <= 1'b0;
      weight_alert_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      floor_q        <= floor_d;
      dir_q          <= dir_d;
      pending_q      <= pending_d;
      timer_q        <= timer_d;
      complete_q     <= complete_d;
      moving_q       <= moving_d;
      door_open_q    <= door_open_d;
      door_alert_q   <= door_alert_d;
      weight_alert_q <= weight_alert_d;
    end
  end
  assign current_floor = floor_q;
  assign direction     = dir_q;
  assign moving        = moving_q;
  assign door_open     = door_open_q;
  assign complete      = complete_q;
  assign door_alert    = door_alert_q;
  assign weight_alert  = weight_alert_q;
  assign pending       = pending_q;
endmodule
